// File: rtl/chiplet_types_pkg.sv
// Shared chiplet types: flit container, egress link TX state encoding and a
// small width helper used wherever a counter or index needs at least one bit.
package chiplet_types_pkg;

  typedef logic [63:0] flit_t;

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} link_tx_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/link_credit_fwd.sv
// Registered credit-return decoder: a returned credit on a VC becomes a
// one-cycle one-hot pulse on the matching bit the following cycle.
module link_credit_fwd
  import chiplet_types_pkg::*;
#(
  parameter int NUM_VCS = 2,
  localparam int VC_W = clog2_min1(NUM_VCS)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               ret_valid_i,
  input  logic [VC_W-1:0]    ret_vc_i,
  output logic [NUM_VCS-1:0] granted_o
);

  logic [NUM_VCS-1:0] granted_q, granted_d;

  // Codes without a matching VC leave every bit clear, so out-of-range credits vanish.
  always_comb begin
    granted_d = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (ret_valid_i && (ret_vc_i == VC_W'(v))) begin
        granted_d[v] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      granted_q <= '0;
    end else begin
      granted_q <= granted_d;
    end
  end

  assign granted_o = granted_q;

endmodule

// File: rtl/switch_link_tx.sv
// Egress link transmitter: takes one flit from the switch crossbar, sends it
// LSB-first as LINK_WIDTH beats on a valid/ready link, and forwards credits.
//
//   state   | meaning
//   TX_IDLE | waiting for data_ready_in; flit captured on the cycle it is seen
//   TX_SEND | presenting beat beat_q; advances on link_ready
//   TX_DONE | packet_sent pulse, flits_sent bump; data_ready_in ignored
module switch_link_tx
  import chiplet_types_pkg::*;
#(
  parameter int FLIT_WIDTH = $bits(flit_t),
  parameter int LINK_WIDTH = 16,
  parameter int NUM_VCS    = 2,
  localparam int VC_W = clog2_min1(NUM_VCS)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  data_ready_in,
  input  logic [FLIT_WIDTH-1:0] flit_in,
  output logic                  packet_sent,
  output logic [LINK_WIDTH-1:0] link_data,
  output logic                  link_valid,
  input  logic                  link_ready,
  input  logic                  credit_return_valid,
  input  logic [VC_W-1:0]       credit_return_vc,
  output logic [NUM_VCS-1:0]    credit_granted,
  output logic [15:0]           flits_sent
);

  localparam int NUM_BEATS = (FLIT_WIDTH + LINK_WIDTH - 1) / LINK_WIDTH;
  localparam int BEAT_W    = clog2_min1(NUM_BEATS);
  localparam int PAD_W     = NUM_BEATS * LINK_WIDTH;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  link_tx_state_t                       state_q, state_d;
  logic [NUM_BEATS-1:0][LINK_WIDTH-1:0] hold_q, hold_d;
  logic [BEAT_W-1:0]                    beat_q, beat_d;
  logic [15:0]                          flits_q, flits_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= TX_IDLE;
      hold_q  <= '0;
      beat_q  <= '0;
      flits_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      beat_q  <= beat_d;
      flits_q <= flits_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    beat_d  = beat_q;
    flits_d = flits_q;
    case (state_q)
      TX_IDLE: begin
        if (data_ready_in) begin
          // Zero-extension here is what pads the upper bits of the final beat.
          hold_d  = PAD_W'(flit_in);
          beat_d  = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (link_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = TX_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      TX_DONE: begin
        flits_d = flits_q + 16'd1;
        state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Outputs depend only on registers, never on link_ready.
  assign link_valid  = (state_q == TX_SEND);
  assign link_data   = link_valid ? hold_q[beat_q] : '0;
  assign packet_sent = (state_q == TX_DONE);
  assign flits_sent  = flits_q;

  link_credit_fwd #(
    .NUM_VCS(NUM_VCS)
  ) u_credit_fwd (
    .clk        (clk),
    .n_rst      (n_rst),
    .ret_valid_i(credit_return_valid),
    .ret_vc_i   (credit_return_vc),
    .granted_o  (credit_granted)
  );

endmodule

// File: tb/tb_switch_link_tx.sv
// Bench for switch_link_tx: a 64/16 two-VC instance and a 40/16 three-VC
// instance, directed sequences, credit vector tables and a randomized run.
module tb_switch_link_tx;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  logic        dr_a = 0, ps_a, lv_a, lr_a = 0, crv_a = 0;
  logic [63:0] flit_a = '0;
  logic [15:0] ld_a, fs_a;
  logic [0:0]  vc_a = '0;
  logic [1:0]  cg_a;

  logic        dr_b = 0, ps_b, lv_b, lr_b = 0, crv_b = 0;
  logic [39:0] flit_b = '0;
  logic [15:0] ld_b, fs_b;
  logic [1:0]  vc_b = '0;
  logic [2:0]  cg_b;

  switch_link_tx u_a (
    .clk(clk), .n_rst(n_rst), .data_ready_in(dr_a), .flit_in(flit_a),
    .packet_sent(ps_a), .link_data(ld_a), .link_valid(lv_a), .link_ready(lr_a),
    .credit_return_valid(crv_a), .credit_return_vc(vc_a),
    .credit_granted(cg_a), .flits_sent(fs_a)
  );

  switch_link_tx #(.FLIT_WIDTH(40), .LINK_WIDTH(16), .NUM_VCS(3)) u_b (
    .clk(clk), .n_rst(n_rst), .data_ready_in(dr_b), .flit_in(flit_b),
    .packet_sent(ps_b), .link_data(ld_b), .link_valid(lv_b), .link_ready(lr_b),
    .credit_return_valid(crv_b), .credit_return_vc(vc_b),
    .credit_granted(cg_b), .flits_sent(fs_b)
  );

  typedef struct {
    logic       v;
    logic [1:0] vc;
    logic [2:0] exp;
  } cvec_t;

  cvec_t tab_a[5];
  cvec_t tab_b[8];

  int checks = 0;
  int errors = 0;
  int sent_a = 0;
  int sent_b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Sends one flit; link_ready is dropped for stall_n cycles while beat stall_at is shown.
  task automatic run_flit(input int sel, input logic [63:0] f, input int stall_at,
                          input int stall_n, input bit hold_after);
    int nb = sel ? 3 : 4;
    int k = 0, c = 0, st = 0, done_c = -1;
    logic v, ps, r;
    logic [15:0] d;
    if (sel) begin dr_b = 1; flit_b = f[39:0]; lr_b = 1; end
    else     begin dr_a = 1; flit_a = f;       lr_a = 1; end
    while (c < 60 && done_c < 0) begin
      @(negedge clk);
      c++;
      v  = sel ? lv_b : lv_a;
      d  = sel ? ld_b : ld_a;
      ps = sel ? ps_b : ps_a;
      if (ps) done_c = c;
      else if (v) begin
        chk("beat_data", d, 16'(f >> (16 * k)));
        if (k == stall_at && st < stall_n) begin r = 0; st++; end
        else begin r = 1; k++; end
        if (sel) lr_b = r; else lr_a = r;
      end
    end
    chk("latency", done_c, nb + stall_n + 1);
    chk("beat_count", k, nb);
    if (sel) sent_b++; else sent_a++;
    if (!hold_after) begin
      if (sel) dr_b = 0; else dr_a = 0;
      @(negedge clk);
      chk("ps_one_cycle", sel ? ps_b : ps_a, 1'b0);
      chk("idle_valid", sel ? lv_b : lv_a, 1'b0);
      chk("flits_sent", sel ? fs_b : fs_a, sel ? sent_b : sent_a);
    end
  endtask

  task automatic cred_tab(input int sel);
    int n = sel ? 8 : 5;
    cvec_t e;
    for (int i = 0; i < n; i++) begin
      e = sel ? tab_b[i] : tab_a[i];
      if (sel) begin crv_b = e.v; vc_b = e.vc; end
      else     begin crv_a = e.v; vc_a = e.vc[0]; end
      @(negedge clk);
      if (sel) chk("credit_b", cg_b, e.exp);
      else     chk("credit_a", cg_a, e.exp[1:0]);
    end
    if (sel) crv_b = 0; else crv_a = 0;
    @(negedge clk);
    chk("credit_clear", sel ? 3'(cg_b) : 3'(cg_a), 3'b000);
  endtask

  task automatic rand_a(input int nflits);
    logic pv = 0;
    logic [0:0] pvc = 0;
    logic [1:0] exp_cg;
    for (int n = 0; n < nflits; n++) begin
      logic [63:0] f = {$urandom, $urandom};
      int gap = $urandom_range(0, 2);
      int k = 0, cyc = 0;
      bit done = 0;
      while (!done && cyc < 200) begin
        @(negedge clk);
        cyc++;
        exp_cg = pv ? (2'b01 << pvc) : 2'b00;
        chk("rand_credit", cg_a, exp_cg);
        pv = 1'($urandom_range(0, 1));
        pvc = 1'($urandom_range(0, 1));
        crv_a = pv;
        vc_a = pvc;
        if (cyc == 1) chk("rand_flits", fs_a, 16'(sent_a));
        if (ps_a) begin
          chk("rand_beats", k, 4);
          done = 1;
          sent_a++;
          dr_a = 0;
        end else begin
          lr_a = 1'($urandom_range(0, 1));
          if (lv_a) begin
            chk("rand_data", ld_a, 16'(f >> (16 * k)));
            if (lr_a) k++;
          end
          if (cyc > gap) begin dr_a = 1; flit_a = f; end
        end
      end
      if (!done) chk("rand_timeout", 0, 1);
    end
    crv_a = 0;
  endtask

  initial begin
    tab_a[0] = '{1'b1, 2'd1, 3'b010};
    tab_a[1] = '{1'b0, 2'd0, 3'b000};
    tab_a[2] = '{1'b1, 2'd0, 3'b001};
    tab_a[3] = '{1'b1, 2'd1, 3'b010};
    tab_a[4] = '{1'b0, 2'd1, 3'b000};
    tab_b[0] = '{1'b1, 2'd0, 3'b001};
    tab_b[1] = '{1'b1, 2'd1, 3'b010};
    tab_b[2] = '{1'b1, 2'd2, 3'b100};
    tab_b[3] = '{1'b1, 2'd3, 3'b000};
    tab_b[4] = '{1'b0, 2'd1, 3'b000};
    tab_b[5] = '{1'b1, 2'd1, 3'b010};
    tab_b[6] = '{1'b0, 2'd0, 3'b000};
    tab_b[7] = '{1'b1, 2'd3, 3'b000};

    #1 n_rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid_a", lv_a, 1'b0);
    chk("rst_data_a", ld_a, 16'h0);
    chk("rst_ps_a", ps_a, 1'b0);
    chk("rst_cg_a", cg_a, 2'b00);
    chk("rst_fs_a", fs_a, 16'h0);
    chk("rst_valid_b", lv_b, 1'b0);
    chk("rst_cg_b", cg_b, 3'b000);
    chk("rst_fs_b", fs_b, 16'h0);
    n_rst = 1;

    // Reset arriving while beat 2 is on the link.
    dr_a = 1; flit_a = 64'hDEAD_BEEF_CAFE_F00D; lr_a = 1;
    repeat (3) @(negedge clk);
    chk("mid_beat2", ld_a, 16'hBEEF);
    #2 n_rst = 0;
    #1 chk("async_valid_fall", lv_a, 1'b0);
    dr_a = 0;
    @(negedge clk);
    n_rst = 1;
    @(negedge clk);
    chk("post_rst_valid", lv_a, 1'b0);
    chk("post_rst_ps", ps_a, 1'b0);
    chk("post_rst_fs", fs_a, 16'h0);
    sent_a = 0;

    run_flit(0, 64'h0123_4567_89AB_CDEF, -1, 0, 0);
    run_flit(0, 64'h0123_4567_89AB_CDEF, 2, 3, 0);

    // Same flit held through DONE, then a new flit in the first IDLE cycle.
    run_flit(0, 64'h1111_2222_3333_4444, -1, 0, 1);
    @(negedge clk);
    chk("held_idle_valid", lv_a, 1'b0);
    chk("held_idle_ps", ps_a, 1'b0);
    chk("held_idle_fs", fs_a, 16'(sent_a));
    run_flit(0, 64'h5555_6666_7777_8888, -1, 0, 0);

    fork
      run_flit(0, 64'hA5A5_5A5A_0F0F_F0F0, -1, 0, 0);
      cred_tab(0);
    join

    run_flit(1, 64'h00_0000_00AB_CDEF_1234, -1, 0, 0);
    run_flit(1, 64'h00_0000_0012_3456_789A, 2, 2, 0);
    cred_tab(1);

    rand_a(40);
    @(negedge clk);
    @(negedge clk);
    chk("final_fs_a", fs_a, 16'(sent_a));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/switch_link_tx.md
Name: switch_link_tx

Overview:
- Egress link transmitter; one instance per switch output port, directly downstream of the switch crossbar.
- Consumes one full flit per handshake from the switch's data_ready_out/out pair. Serializes it LSB-first into LINK_WIDTH-bit beats on a valid/ready physical link.
- Returns the packet_sent pulse to the switch. Forwards far-end credit returns to the switch as per-VC credit_granted pulses.

Parameters:
- FLIT_WIDTH, 64: width of flit_t; must equal $bits(flit_t).
- LINK_WIDTH, 16: link beat width; 1 <= LINK_WIDTH <= FLIT_WIDTH.
- NUM_VCS, 2: virtual channels; credit_return_vc width is $clog2(NUM_VCS), minimum 1.

Ports:
- clk  in  1  clock; single clock domain.
- n_rst  in  1  reset; asynchronous, active-low.
- data_ready_in  in  1  switch data_ready_out for this port; held high with a stable flit until packet_sent.
- flit_in  in  FLIT_WIDTH  flit from the switch crossbar out.
- packet_sent  out  1  one-cycle pulse to the switch: flit fully transmitted.
- link_data  out  LINK_WIDTH  current beat.
- link_valid  out  1  beat valid.
- link_ready  in  1  PHY accepts beat when link_valid && link_ready.
- credit_return_valid  in  1  far-end buffer freed a slot.
- credit_return_vc  in  $clog2(NUM_VCS)  VC of the returned credit.
- credit_granted  out  NUM_VCS  one-hot one-cycle pulse to the switch credit_granted for this port.
- flits_sent  out  16  wrapping count of completed flits (debug).

Behaviour:
- Constants:
  - NUM_BEATS = ceil(FLIT_WIDTH/LINK_WIDTH).
  - Beat counter width $clog2(NUM_BEATS), minimum 1.
  - Final beat is zero-padded in its upper bits.
- Reset values: state IDLE, hold register 0, beat counter 0, packet_sent 0, link_valid 0, link_data 0, credit_granted 0, flits_sent 0.
- Reset is asynchronous mid-operation: the partial flit is dropped and link_valid falls immediately. The switch reset clears its side.
- FSM states: IDLE, SEND, DONE.
  - IDLE: if data_ready_in, latch flit_in into the hold register, beat=0, go to SEND next cycle. link_valid=0 in IDLE.
  - SEND: link_valid=1 and link_data=hold[beat*LINK_WIDTH +: LINK_WIDTH] (zero-extended).
    - On link_valid && link_ready with beat != NUM_BEATS-1: beat increments.
    - On acceptance of the last beat: go to DONE. link_ready low holds the beat and data stable.
  - DONE: packet_sent=1 for exactly this cycle, flits_sent increments (wraps 0xFFFF->0), next state IDLE. data_ready_in is ignored in DONE, because the switch may still show the old flit this cycle.
- Latency: capture cycle + NUM_BEATS beats (with link_ready=1) + 1 DONE cycle. Minimum spacing between flits is NUM_BEATS+2 cycles.
- packet_sent, link_valid and link_data are driven from registers (state and hold register); no combinational path from link_ready.
- Credits:
  - credit_granted is registered: cycle after credit_return_valid, credit_granted[credit_return_vc]=1 for one cycle; otherwise 0.
  - An out-of-range credit_return_vc (>= NUM_VCS) is dropped.
  - The credit path is independent of the FSM and works in every state.
- NUM_BEATS==1 is legal: SEND lasts one accepted beat.

Decomposition:
- chiplet_types_pkg supplies flit_t; FLIT_WIDTH defaults to $bits(flit_t).
- Add to package: typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} link_tx_state_t.
- One natural sub-module: link_credit_fwd (registered credit_return -> one-hot credit_granted decoder), reusable by the RX side.

Test Plan:
- Single flit: reset, flit_in=64'h0123_4567_89AB_CDEF, data_ready_in=1, link_ready=1 -> beats CDEF, 89AB, 4567, 0123 on consecutive cycles; packet_sent pulses once the cycle after beat 0123; flits_sent=1.
- Backpressure: same flit, link_ready low for 3 cycles on beat 2 -> link_data holds 4567 with link_valid=1; no skipped or duplicated beats; packet_sent delayed by 3 cycles.
- Held input: data_ready_in kept high through DONE with the same flit -> exactly one transmission per packet_sent. A new flit presented in the first IDLE cycle after DONE is captured.
- Padding: FLIT_WIDTH=40, LINK_WIDTH=16, flit 40'hAB_CDEF_1234 -> beats 1234, CDEF, 00AB.
- Credits: credit_return_valid with vc=1 while in SEND -> credit_granted=2'b10 next cycle for one cycle. Back-to-back vc=0 then vc=1 -> 2'b01 then 2'b10. vc out of range with NUM_VCS=3 -> no pulse.
- Reset mid-flit: assert n_rst after beat 1 -> link_valid falls asynchronously; after release state is IDLE; the next flit sends from beat 0; flits_sent is unchanged from 0.
